// File: rtl/fp_activation_stream.sv
// fp_activation_stream
//
// Streaming activation stage. It registers each accepted beat and evaluates
// sigmoid, tanh or bypass according to the per-beat mode. Results are queued
// in a small FIFO so the consumer never sees a combinational activation path.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_data, in_mode        operand and function select
//                           (00 bypass, 01 sigmoid, 10 tanh, 11 bypass + error)
//   in_last                 last beat of a vector
//   out_valid/out_ready     output handshake on the FIFO head
//   out_data, out_last      result and its vector-end flag
//   elem_count              beats popped in the current vector (saturating)
//   vec_done                one-cycle pulse after the last beat of a vector pops
//   mode_err                sticky flag for accepted beats with mode 11
//
// Also contains the combinational floating_point_sigmoid/floating_point_tanh
// units. Both share fp_act_core, a piecewise-linear sigmoid evaluated in
// fixed point (16 fraction bits). Tanh uses tanh(x) = 2*sigmoid(2x) - 1.
// Denormal inputs are treated as zero. |x| >= 8 saturates.

module fp_act_core #(
    parameter int M    = 23,
    parameter int E    = 8,
    parameter bit TANH = 1'b0
) (
    input  logic         en,
    input  logic [E+M:0] x,
    output logic [E+M:0] y
);
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int F    = 16;

    logic         sign;
    logic [E-1:0] expo;
    logic [M:0]   sig;
    logic [63:0]  tmp;
    logic [63:0]  tmp2;
    logic [18:0]  mag;
    logic [18:0]  sg;
    logic [18:0]  r;
    logic         rsign;
    int           ue;
    int           sh;
    int           p;
    int           exp_i;

    assign sign = x[E+M];
    assign expo = x[E+M-1:M];
    assign sig  = {1'b1, x[M-1:0]};

    // Convert to a Q3.16 magnitude, run the sigmoid segments, then renormalise.
    // Tanh doubles the operand by bumping the unbiased exponent.
    always_comb begin
        tmp   = '0;
        tmp2  = '0;
        mag   = '0;
        sg    = '0;
        r     = '0;
        rsign = 1'b0;
        ue    = 0;
        sh    = 0;
        p     = 0;
        exp_i = 0;
        y     = '0;

        if (expo != '0) begin
            ue = int'(expo) - BIAS + (TANH ? 1 : 0);
            if (ue >= 3) begin
                mag = '1;
            end else begin
                sh  = M - F - ue;
                tmp = 64'(sig);
                if (sh >= 0)
                    tmp = tmp >> sh;
                else
                    tmp = tmp << (-sh);
                mag = tmp[18:0];
            end
        end

        // Segments: slope 1/4, 1/8, 1/32, then flat at 1.0.
        if (mag >= 19'd327680)
            sg = 19'd65536;
        else if (mag >= 19'd155648)
            sg = (mag >> 5) + 19'd55296;
        else if (mag >= 19'd65536)
            sg = (mag >> 3) + 19'd40960;
        else
            sg = (mag >> 2) + 19'd32768;

        // sg is always at least 0.5, so the tanh form cannot go negative.
        if (TANH) begin
            r     = (sg << 1) - 19'd65536;
            rsign = sign;
        end else begin
            r     = sign ? (19'd65536 - sg) : sg;
            rsign = 1'b0;
        end

        for (int i = 0; i < 19; i++) begin
            if (r[i])
                p = i;
        end

        if (r != '0) begin
            exp_i = BIAS + p - F;
            tmp2  = 64'(r) << M;
            tmp2  = tmp2 >> p;
            y     = {rsign, exp_i[E-1:0], tmp2[M-1:0]};
        end else begin
            y = {rsign, {(E + M){1'b0}}};
        end

        if (!en)
            y = '0;
    end
endmodule

module floating_point_sigmoid #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         en,
    input  logic [E+M:0] x,
    output logic [E+M:0] y
);
    fp_act_core #(.M(M), .E(E), .TANH(1'b0)) u_core (.en(en), .x(x), .y(y));
endmodule

module floating_point_tanh #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         en,
    input  logic [E+M:0] x,
    output logic [E+M:0] y
);
    fp_act_core #(.M(M), .E(E), .TANH(1'b1)) u_core (.en(en), .x(x), .y(y));
endmodule

module fp_activation_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int M          = 23,
    parameter int E          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [15:0]           elem_count,
    output logic                  vec_done,
    output logic                  mode_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [1:0]            s1_mode;
    logic                  s1_last;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_count;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  sig_en;
    logic                  tanh_en;
    logic [DATA_WIDTH-1:0] sig_y;
    logic [DATA_WIDTH-1:0] tanh_y;
    logic [DATA_WIDTH-1:0] act_result;
    logic                  s1_is_nan;

    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && ((fifo_count < (AW + 1)'(FIFO_DEPTH)) || pop);
    assign in_ready  = !s1_valid || push;
    assign accept    = in_valid && in_ready;
    assign out_valid = (fifo_count != '0);

    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign out_data  = out_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign out_last  = out_valid ? mem[rd_ptr][DATA_WIDTH] : 1'b0;

    assign sig_en    = (s1_mode == 2'b01);
    assign tanh_en   = (s1_mode == 2'b10);
    assign s1_is_nan = (s1_data[M+E-1:M] == '1) && (s1_data[M-1:0] != '0);

    floating_point_sigmoid #(.M(M), .E(E)) u_sigmoid (
        .en (sig_en),
        .x  (s1_data),
        .y  (sig_y)
    );

    floating_point_tanh #(.M(M), .E(E)) u_tanh (
        .en (tanh_en),
        .x  (s1_data),
        .y  (tanh_y)
    );

    // Select the activation. NaN operands of the real functions collapse to
    // the canonical quiet NaN. Bypass keeps the payload bits.
    always_comb begin
        act_result = s1_data;
        if (sig_en || tanh_en) begin
            if (s1_is_nan)
                act_result = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};
            else if (sig_en)
                act_result = sig_y;
            else
                act_result = tanh_y;
        end
    end

    // Stage 1 register: load on accept, otherwise empty out once pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 2'b00;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_mode  <= in_mode;
            s1_last  <= in_last;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    // FIFO storage needs no reset because the head is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s1_last, act_result};
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Vector tracking on the consumer side, plus the sticky illegal-mode flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_count <= '0;
            vec_done   <= 1'b0;
            mode_err   <= 1'b0;
        end else begin
            vec_done <= pop && out_last;
            if (pop) begin
                if (out_last)
                    elem_count <= '0;
                else if (elem_count != 16'hFFFF)
                    elem_count <= elem_count + 16'd1;
            end
            if (accept && (in_mode == 2'b11))
                mode_err <= 1'b1;
        end
    end
endmodule
